// File: rtl/mips_writeback.sv
// rtl/mips_writeback.sv - MIPS write-back stage: ALU/load retire, lane extract, register-file write port (optional WB_FWD_EN bypass)
module mips_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_load_type,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  misalign,
`ifdef WB_FWD_EN
    input  logic [ADDR_WIDTH-1:0] fwd_raddr1,
    input  logic [ADDR_WIDTH-1:0] fwd_raddr2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DATA_WIDTH-1:0] fwd_data,
`endif
    output logic                  busy
);

    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd4;
    localparam logic [2:0] LT_LHU = 3'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] rd_q;
    logic [1:0]            lo_q;
    logic [2:0]            type_q;
    logic                  wen_q;
    logic                  mis_q;

    logic                  accept;
    logic                  in_mis;
    logic                  load_done;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_WIDTH-1:0] load_data;

    assign in_ready  = (state != WAIT_MEM);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign load_done = (state == WAIT_MEM) && mem_rdata_valid;

    // Alignment is judged at acceptance so the latched flag alone decides the completion
    always_comb begin
        in_mis = 1'b0;
        case (in_load_type)
            LT_LB, LT_LBU: in_mis = 1'b0;
            LT_LH, LT_LHU: in_mis = in_result[0];
            default:       in_mis = (in_result[1:0] != 2'b00);
        endcase
    end

    // Little-endian lane select and sign/zero extension of the returned word
    always_comb begin
        sel_byte = 8'h00;
        case (lo_q)
            2'd0:    sel_byte = mem_rdata[7:0];
            2'd1:    sel_byte = mem_rdata[15:8];
            2'd2:    sel_byte = mem_rdata[23:16];
            default: sel_byte = mem_rdata[31:24];
        endcase
        sel_half  = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (type_q)
            LT_LB:   load_data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
            LT_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
            LT_LH:   load_data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
            LT_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
            default: load_data = mem_rdata;
        endcase
    end

    // Next-state: WRITE always lasts one cycle unless another instruction is accepted
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, WRITE: begin
                if (accept) begin
                    state_nxt = in_is_load ? WAIT_MEM : WRITE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT_MEM: begin
                if (mem_rdata_valid) begin
                    state_nxt = WRITE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the pending load context while memory is outstanding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q   <= '0;
            lo_q   <= 2'b00;
            type_q <= 3'd0;
            wen_q  <= 1'b0;
            mis_q  <= 1'b0;
        end else if (accept && in_is_load) begin
            rd_q   <= in_rd;
            lo_q   <= in_result[1:0];
            type_q <= in_load_type;
            wen_q  <= in_wen;
            mis_q  <= in_mis;
        end
    end

    // Registered register-file write port and misalign pulse; both default low each cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            misalign <= 1'b0;
        end else begin
            rf_wen   <= 1'b0;
            misalign <= 1'b0;
            if (load_done) begin
                rf_wen   <= wen_q && (rd_q != '0) && !mis_q;
                misalign <= mis_q;
                rf_waddr <= rd_q;
                rf_wdata <= load_data;
            end else if (accept && !in_is_load) begin
                rf_wen   <= in_wen && (in_rd != '0);
                rf_waddr <= in_rd;
                rf_wdata <= in_result;
            end
        end
    end

`ifdef WB_FWD_EN
    // Bypass for decode reading a register in the same cycle it is written
    assign fwd_hit1 = rf_wen && (rf_waddr == fwd_raddr1) && (fwd_raddr1 != '0);
    assign fwd_hit2 = rf_wen && (rf_waddr == fwd_raddr2) && (fwd_raddr2 != '0);
    assign fwd_data = rf_wdata;
`endif

endmodule

// File: tb/tb_mips_writeback.sv
// tb/tb_mips_writeback.sv - directed scoreboard bench for mips_writeback
module tb_mips_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        in_is_load;
    logic [2:0]  in_load_type;
    logic [31:0] in_result;
    logic        mem_rdata_valid;
    logic [31:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        misalign;
    logic        busy;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_raddr1;
    logic [4:0]  fwd_raddr2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data;
`endif

    mips_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_rd           (in_rd),
        .in_wen          (in_wen),
        .in_is_load      (in_is_load),
        .in_load_type    (in_load_type),
        .in_result       (in_result),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata),
        .rf_wen          (rf_wen),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .misalign        (misalign),
`ifdef WB_FWD_EN
        .fwd_raddr1      (fwd_raddr1),
        .fwd_raddr2      (fwd_raddr2),
        .fwd_hit1        (fwd_hit1),
        .fwd_hit2        (fwd_hit2),
        .fwd_data        (fwd_data),
`endif
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write or misalign pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst && (rf_wen || misalign)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {30'd0, misalign, rf_wen}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_misalign", {31'd0, misalign}, {31'd0, e.mis});
                chk("sb_wen", {31'd0, rf_wen}, {31'd0, !e.mis});
                if (!e.mis) begin
                    chk("sb_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
                    chk("sb_wdata", rf_wdata, e.data);
                end
            end
        end
    end

    function automatic logic [31:0] load_model(input logic [2:0] t, input logic [1:0] lo,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lo +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (t)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic is_mis(input logic [2:0] t, input logic [1:0] lo);
        if (t == 3'd0 || t == 3'd4) return 1'b0;
        if (t == 3'd1 || t == 3'd5) return lo[0];
        return lo != 2'b00;
    endfunction

    task automatic send_alu(input logic [4:0] rd, input logic wen, input logic [31:0] res);
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        in_rd      = rd;
        in_wen     = wen;
        in_result  = res;
        if (wen && rd != 5'd0) exp_q.push_back('{1'b0, rd, res});
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic wen, input logic [2:0] t,
                           input logic [31:0] addr, input logic [31:0] word, input int wait_cyc);
        logic m;
        m = is_mis(t, addr[1:0]);
        in_valid     = 1'b1;
        in_is_load   = 1'b1;
        in_rd        = rd;
        in_wen       = wen;
        in_load_type = t;
        in_result    = addr;
        if (m) exp_q.push_back('{1'b1, rd, 32'd0});
        else if (wen && rd != 5'd0) exp_q.push_back('{1'b0, rd, load_model(t, addr[1:0], word)});
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < wait_cyc; i++) begin
            chk("wait_ready", {31'd0, in_ready}, 32'd0);
            chk("wait_wen", {31'd0, rf_wen}, 32'd0);
            cyc();
        end
        mem_rdata_valid = 1'b1;
        mem_rdata       = word;
        cyc();
        mem_rdata_valid = 1'b0;
        chk("load_wen", {31'd0, rf_wen}, {31'd0, wen && rd != 5'd0 && !m});
        chk("load_misalign", {31'd0, misalign}, {31'd0, m});
        if (!m && wen && rd != 5'd0) chk("load_wdata", rf_wdata, load_model(t, addr[1:0], word));
    endtask

    initial begin
        rst             = 1'b0;
        in_valid        = 1'b0;
        in_rd           = 5'd0;
        in_wen          = 1'b0;
        in_is_load      = 1'b0;
        in_load_type    = 3'd0;
        in_result       = 32'd0;
        mem_rdata_valid = 1'b0;
        mem_rdata       = 32'd0;
`ifdef WB_FWD_EN
        fwd_raddr1      = 5'd0;
        fwd_raddr2      = 5'd0;
`endif
        cyc();
        cyc();
        chk("rst_wen", {31'd0, rf_wen}, 32'd0);
        chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;
        cyc();

        // single non-load
        send_alu(5'd5, 1'b1, 32'h1234_5678);
        chk("alu_wen", {31'd0, rf_wen}, 32'd1);
        chk("alu_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("alu_wdata", rf_wdata, 32'h1234_5678);
        cyc();
        chk("alu_wen_drop", {31'd0, rf_wen}, 32'd0);
        chk("alu_hold_wdata", rf_wdata, 32'h1234_5678);

        // back-to-back non-loads
        for (int i = 1; i <= 3; i++) begin
            chk("b2b_ready", {31'd0, in_ready}, 32'd1);
            in_valid   = 1'b1;
            in_is_load = 1'b0;
            in_rd      = i[4:0];
            in_wen     = 1'b1;
            in_result  = 32'hA000_0000 + i;
            exp_q.push_back('{1'b0, i[4:0], 32'hA000_0000 + i});
            cyc();
            chk("b2b_wen", {31'd0, rf_wen}, 32'd1);
            chk("b2b_waddr", {27'd0, rf_waddr}, i);
        end
        in_valid = 1'b0;
        cyc();
        chk("b2b_idle", {31'd0, rf_wen}, 32'd0);

        // loads: lane select and extension
        do_load(5'd8,  1'b1, 3'd0, 32'h0000_1003, 32'h80FF_0011, 4);
        cyc();
        do_load(5'd9,  1'b1, 3'd4, 32'h0000_1003, 32'h80FF_0011, 1);
        cyc();
        do_load(5'd10, 1'b1, 3'd5, 32'h0000_2002, 32'h9ABC_0000, 2);
        cyc();
        do_load(5'd11, 1'b1, 3'd1, 32'h0000_2002, 32'h9ABC_0000, 0);
        cyc();
        do_load(5'd12, 1'b1, 3'd0, 32'h0000_2000, 32'h80FF_0011, 0);
        cyc();
        do_load(5'd13, 1'b1, 3'd1, 32'h0000_2000, 32'h0000_8001, 1);
        cyc();
        do_load(5'd14, 1'b1, 3'd2, 32'h0000_2000, 32'hDEAD_BEEF, 3);
        cyc();
        do_load(5'd15, 1'b1, 3'd3, 32'h0000_2000, 32'hCAFE_F00D, 0);
        cyc();
        do_load(5'd16, 1'b1, 3'd4, 32'h0000_2001, 32'h1234_56F7, 0);
        cyc();

        // misaligned loads: no write, single misalign pulse
        do_load(5'd17, 1'b1, 3'd2, 32'h0000_3001, 32'h1111_2222, 2);
        cyc();
        chk("mis_one_cycle", {31'd0, misalign}, 32'd0);
        do_load(5'd18, 1'b1, 3'd1, 32'h0000_3003, 32'h1111_2222, 0);
        cyc();
        chk("mis_one_cycle2", {31'd0, misalign}, 32'd0);

        // load without register write, then rd=0 non-load
        do_load(5'd19, 1'b0, 3'd2, 32'h0000_4000, 32'h5555_AAAA, 1);
        cyc();
        send_alu(5'd0, 1'b1, 32'hFFFF_FFFF);
        chk("rd0_wen", {31'd0, rf_wen}, 32'd0);
        cyc();

        // load completion followed by a non-load accepted in WRITE
        do_load(5'd20, 1'b1, 3'd2, 32'h0000_5000, 32'h0BAD_CAFE, 0);
        chk("write_ready", {31'd0, in_ready}, 32'd1);
        send_alu(5'd21, 1'b1, 32'h7777_0001);
        chk("after_load_alu", rf_wdata, 32'h7777_0001);
        cyc();

        // stray memory valid in IDLE is ignored
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'h1357_9BDF;
        cyc();
        mem_rdata_valid = 1'b0;
        chk("stray_valid_wen", {31'd0, rf_wen}, 32'd0);
        chk("stray_valid_busy", {31'd0, busy}, 32'd0);

        // reset in the middle of an outstanding load
        in_valid     = 1'b1;
        in_is_load   = 1'b1;
        in_rd        = 5'd22;
        in_wen       = 1'b1;
        in_load_type = 3'd2;
        in_result    = 32'h0000_6000;
        cyc();
        in_valid = 1'b0;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_wdata", rf_wdata, 32'd0);
        chk("mid_rst_waddr", {27'd0, rf_waddr}, 32'd0);
        cyc();
        rst = 1'b1;
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'h2468_ACE0;
        cyc();
        mem_rdata_valid = 1'b0;
        chk("post_rst_wen", {31'd0, rf_wen}, 32'd0);
        chk("post_rst_mis", {31'd0, misalign}, 32'd0);
        cyc();

`ifdef WB_FWD_EN
        fwd_raddr1 = 5'd7;
        fwd_raddr2 = 5'd0;
        send_alu(5'd7, 1'b1, 32'h0F0F_1234);
        chk("fwd_hit1", {31'd0, fwd_hit1}, 32'd1);
        chk("fwd_hit2", {31'd0, fwd_hit2}, 32'd0);
        chk("fwd_data", fwd_data, 32'h0F0F_1234);
        cyc();
        chk("fwd_hit1_off", {31'd0, fwd_hit1}, 32'd0);
`endif

        cyc();
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
